// File: rtl/ddc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddc_pkg : shared FSM encoding, clip limits and log2 helper          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package ddc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddc_decim_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddc_decim_ch : one channel of the decimator - block accumulator,    |
// | round-half-up average, optional DC blocker (DDC_DECIM_DCBLK_EN),    |
// | 16-bit saturation and output register.                              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ddc_decim_ch
  import ddc_pkg::*;
#(
  parameter int DECIM = 8
`ifdef DDC_DECIM_DCBLK_EN
  , parameter int DC_SHIFT = 10
`endif
) (
  input  logic               clk_200m,
  input  logic               cfg_rst,
  input  logic               clr,
  input  logic               accept,
  input  logic               first,
  input  logic               emit,
  input  logic signed [15:0] din,
  output logic signed [15:0] dout,
  output logic               clip
);

  localparam int c_lg = clog2(DECIM);
  localparam int c_aw = 16 + c_lg;
  localparam int c_yw = 33;
  localparam logic signed [c_aw-1:0] c_half = c_aw'(DECIM / 2);
  localparam logic signed [c_yw-1:0] c_max  = c_yw'(SAT_MAX);
  localparam logic signed [c_yw-1:0] c_min  = c_yw'(SAT_MIN);

  logic signed [c_aw-1:0] r_acc;
  logic signed [15:0]     r_dout;
  logic signed [c_aw-1:0] w_din_ext;
  logic signed [c_aw-1:0] w_sum;
  logic signed [c_aw-1:0] w_rnd;
  logic signed [c_yw-1:0] w_y;
  logic signed [15:0]     w_sat;
  logic                   w_hi;
  logic                   w_lo;

  // The full block sum is formed combinationally so the result registers
  // on the same edge that accepts the last sample of the block.
  assign w_din_ext = c_aw'(din);
  assign w_sum     = first ? w_din_ext : r_acc + w_din_ext;
  assign w_rnd     = (w_sum + c_half) >>> c_lg;

`ifdef DDC_DECIM_DCBLK_EN
  logic signed [31:0] r_est;
  logic signed [31:0] w_est_sh;

  assign w_est_sh = r_est >>> DC_SHIFT;
  assign w_y      = c_yw'(w_rnd) - c_yw'(w_est_sh);

  // Estimate only moves on emitted outputs, so it is frozen while idle.
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_est <= '0;
    end else if (emit) begin
      r_est <= r_est + 32'(w_sat);
    end
  end
`else
  assign w_y = c_yw'(w_rnd);
`endif

  assign w_hi  = (w_y > c_max);
  assign w_lo  = (w_y < c_min);
  assign w_sat = w_hi ? SAT_MAX : (w_lo ? SAT_MIN : w_y[15:0]);

  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_acc  <= '0;
      r_dout <= '0;
    end else begin
      if (clr) begin
        r_acc <= '0;
      end else if (accept) begin
        r_acc <= w_sum;
      end
      if (emit) begin
        r_dout <= w_sat;
      end
    end
  end

  assign dout = r_dout;
  assign clip = w_hi | w_lo;

endmodule
`default_nettype wire

// File: rtl/ddc_decim.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddc_decim : I/Q block-average decimator with settle FSM.            |
// | Define DDC_DECIM_DCBLK_EN to build in the per-channel DC blocker.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ddc_decim
  import ddc_pkg::*;
#(
  parameter int DECIM       = 8,
  parameter int SETTLE_BLKS = 4,
  parameter int DC_SHIFT    = 10
) (
  input  logic               clk_200m,
  input  logic               cfg_rst,
  input  logic               rx_en,
  input  logic signed [15:0] din_i,
  input  logic signed [15:0] din_q,
  output logic signed [15:0] dout_i,
  output logic signed [15:0] dout_q,
  output logic               dout_valid,
  output logic               sat,
  output logic [1:0]         state_dbg
);

  localparam int c_lg = clog2(DECIM);
  localparam int c_sw = (clog2(SETTLE_BLKS + 1) < 1) ? 1 : clog2(SETTLE_BLKS + 1);

  if ((DECIM < 2) || (DECIM > 64) || ((1 << c_lg) != DECIM)) begin : g_bad_decim
    $error("ddc_decim: DECIM must be a power of two in 2..64");
  end

  if ((DC_SHIFT < 0) || (DC_SHIFT > 30)) begin : g_bad_dc_shift
    $error("ddc_decim: DC_SHIFT must be in 0..30");
  end

  state_t          r_state;
  logic [c_lg-1:0] r_phase;
  logic [c_sw-1:0] r_settle;
  logic            r_valid;
  logic            r_sat;
  logic            w_first;
  logic            w_last;
  logic            w_emit;
  logic            w_clip_i;
  logic            w_clip_q;

  assign w_first = (r_phase == '0);
  assign w_last  = rx_en && (r_phase == c_lg'(DECIM - 1));
  assign w_emit  = w_last && (r_state == S_RUN);

  // Every cycle with rx_en high accepts a sample, including the IDLE cycle
  // that starts block 0; rx_en low abandons any partial block.
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_settle <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_sat   <= w_emit && (w_clip_i || w_clip_q);
      if (!rx_en) begin
        r_state  <= S_IDLE;
        r_phase  <= '0;
        r_settle <= '0;
      end else begin
        r_phase <= r_phase + c_lg'(1);
        case (r_state)
          S_IDLE: begin
            r_state <= (SETTLE_BLKS == 0) ? S_RUN : S_SETTLE;
          end
          S_SETTLE: begin
            if (w_last) begin
              if (r_settle == c_sw'(SETTLE_BLKS - 1)) begin
                r_state  <= S_RUN;
                r_settle <= '0;
              end else begin
                r_settle <= r_settle + c_sw'(1);
              end
            end
          end
          S_RUN: begin
            r_state <= S_RUN;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  ddc_decim_ch #(
    .DECIM    (DECIM)
`ifdef DDC_DECIM_DCBLK_EN
    , .DC_SHIFT (DC_SHIFT)
`endif
  ) u_ch_i (
    .clk_200m (clk_200m),
    .cfg_rst  (cfg_rst),
    .clr      (!rx_en),
    .accept   (rx_en),
    .first    (w_first),
    .emit     (w_emit),
    .din      (din_i),
    .dout     (dout_i),
    .clip     (w_clip_i)
  );

  ddc_decim_ch #(
    .DECIM    (DECIM)
`ifdef DDC_DECIM_DCBLK_EN
    , .DC_SHIFT (DC_SHIFT)
`endif
  ) u_ch_q (
    .clk_200m (clk_200m),
    .cfg_rst  (cfg_rst),
    .clr      (!rx_en),
    .accept   (rx_en),
    .first    (w_first),
    .emit     (w_emit),
    .din      (din_q),
    .dout     (dout_q),
    .clip     (w_clip_q)
  );

  assign dout_valid = r_valid;
  assign sat        = r_sat;
  assign state_dbg  = r_state;

endmodule
`default_nettype wire
